// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART boot loader.
// Loader FSM encoding, receiver states, word sizing, baud divisor helper.
package uart_loader_pkg;

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam int WORD_BYTES = 4;
  localparam int ADDR_STEP  = 4;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling, glitch reject.
// Emits a one-cycle rx_valid per good byte, frame_bad on a low stop bit.
module uart_rx
  import uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_bad
);

  localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]  r_sync;
  logic        r_prev;
  rx_state_t   r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;

  // bring the async line into the clock domain, keep last value for edges
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= 2'b11;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], i_rx};
      r_prev <= r_sync[1];
    end
  end

  // bit timer and deserializer, samples each bit near its centre
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= RX_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      frame_bad <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_bad <= 1'b0;
      unique case (r_state)
        RX_IDLE: begin
          r_cnt <= '0;
          if (r_prev && !r_sync[1]) r_state <= RX_START;
        end
        RX_START: begin
          if (r_cnt == HALF) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= r_sync[1] ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        RX_DATA: begin
          if (r_cnt == FULL) begin
            r_cnt   <= '0;
            r_shift <= {r_sync[1], r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_state <= RX_STOP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        RX_STOP: begin
          if (r_cnt == FULL) begin
            r_cnt   <= '0;
            r_state <= RX_IDLE;
            if (r_sync[1]) begin
              rx_byte  <= r_shift;
              rx_valid <= 1'b1;
            end else begin
              frame_bad <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_mem_loader.sv
// Boot loader: holds the CPU in reset, streams a UART image into memory,
// then releases the CPU. Image = LE word count N followed by N LE words.
module uart_mem_loader
  import uart_loader_pkg::*;
#(
  parameter int          CLK_FREQ     = 50000000,
  parameter int          BAUD         = 115200,
  parameter int          CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD),
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          MAX_WORDS    = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rx,
  output logic        cpu_reset_out,
  output logic        ext_mem_write,
  output logic [31:0] ext_write_data,
  output logic [31:0] ext_data_adr,
  output logic        load_done,
  output logic        load_err,
  output logic        frame_err
);

  localparam logic [31:0] MAX_W   = 32'(MAX_WORDS);
  localparam logic [31:0] STEP    = 32'(ADDR_STEP);
  localparam logic [1:0]  LAST_BY = 2'(WORD_BYTES - 1);

  logic [7:0]  w_rx_byte;
  logic        w_rx_valid;
  logic        w_frame_bad;
  logic [31:0] w_word;

  state_t      r_state;
  logic [1:0]  r_bcnt;
  logic [31:0] r_word;
  logic [31:0] r_len;
  logic [31:0] r_idx;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk      (clk),
    .reset    (reset),
    .i_rx     (uart_rx),
    .rx_byte  (w_rx_byte),
    .rx_valid (w_rx_valid),
    .frame_bad(w_frame_bad)
  );

  // first byte ends up in [7:0] after four shifts
  assign w_word = {w_rx_byte, r_word[31:8]};

  // sticky framing flag, independent of loader progress
  always_ff @(posedge clk) begin
    if (reset) frame_err <= 1'b0;
    else if (w_frame_bad) frame_err <= 1'b1;
  end

  // loader FSM with registered memory-port and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_LEN;
      r_bcnt         <= '0;
      r_word         <= '0;
      r_len          <= '0;
      r_idx          <= '0;
      cpu_reset_out  <= 1'b1;
      ext_mem_write  <= 1'b0;
      ext_write_data <= '0;
      ext_data_adr   <= BASE_ADDR;
      load_done      <= 1'b0;
      load_err       <= 1'b0;
    end else begin
      ext_mem_write <= 1'b0;
      unique case (r_state)
        S_LEN: begin
          if (w_rx_valid) begin
            r_word <= w_word;
            r_bcnt <= r_bcnt + 2'd1;
            if (r_bcnt == LAST_BY) begin
              r_len <= w_word;
              if (w_word == '0) begin
                r_state       <= S_DONE;
                cpu_reset_out <= 1'b0;
                load_done     <= 1'b1;
              end else if (w_word > MAX_W) begin
                r_state  <= S_ERR;
                load_err <= 1'b1;
              end else begin
                r_state <= S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (w_rx_valid) begin
            r_word <= w_word;
            r_bcnt <= r_bcnt + 2'd1;
            if (r_bcnt == LAST_BY) begin
              r_state        <= S_WRITE;
              ext_mem_write  <= 1'b1;
              ext_write_data <= w_word;
              ext_data_adr   <= BASE_ADDR + r_idx * STEP;
            end
          end
        end
        S_WRITE: begin
          r_idx <= r_idx + 32'd1;
          if (r_idx + 32'd1 == r_len) begin
            r_state       <= S_DONE;
            cpu_reset_out <= 1'b0;
            load_done     <= 1'b1;
          end else begin
            r_state <= S_DATA;
          end
        end
        S_DONE: r_state <= S_DONE;
        S_ERR:  r_state <= S_ERR;
        default: r_state <= S_ERR;
      endcase
    end
  end

endmodule

// File: doc/uart_mem_loader.md
Name: uart_mem_loader

Overview:
Boot loader that sits directly upstream of the SoC top level and drives its external memory-write port. After reset it holds the CPU in reset, receives a program image over a UART line (8N1), assembles little-endian 32-bit words and writes them into data memory through the external write interface. Once the image is loaded, it releases the CPU. Its outputs connect one-to-one to the top-level reset, Ext_MemWrite, Ext_WriteData and Ext_DataAdr inputs.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 115200, UART bit rate
CLKS_PER_BIT, CLK_FREQ/BAUD, clocks per UART bit (derived, must be >= 4)
BASE_ADDR, 32'h0000_0000, byte address of the first loaded word
MAX_WORDS, 1024, largest accepted image length in words

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
uart_rx  input  1  asynchronous serial input, idle high
cpu_reset_out  output  1  drives the top-level reset; 1 while loading
ext_mem_write  output  1  one-cycle write strobe to the top-level Ext_MemWrite
ext_write_data  output  32  word to write, drives Ext_WriteData
ext_data_adr  output  32  byte address, drives Ext_DataAdr
load_done  output  1  image fully written, CPU released
load_err  output  1  sticky; header length exceeded MAX_WORDS
frame_err  output  1  sticky; at least one byte had stop bit = 0

Behaviour:
- Reset values: cpu_reset_out=1, ext_mem_write=0, ext_write_data=0, ext_data_adr=BASE_ADDR, load_done=0, load_err=0, frame_err=0. The FSM enters S_LEN and the byte and word counters clear. A reset asserted mid-image aborts the load and restarts from S_LEN. There is no partial resume.
- RX path:
  - uart_rx passes through a 2-FF synchronizer.
  - A falling edge in IDLE starts a frame. The line is sampled at CLKS_PER_BIT/2; if it is high, the frame is treated as a glitch and the receiver returns to IDLE.
  - 8 data bits are then sampled every CLKS_PER_BIT, LSB first, followed by the stop bit.
  - Stop bit = 1: rx_valid pulses for 1 cycle with rx_byte.
  - Stop bit = 0: the byte is discarded and frame_err is set.
  - The receiver returns to IDLE after the stop-bit sample.
- Protocol: 4-byte little-endian word count N, then N words, each 4 bytes little-endian (first byte goes to bits [7:0]).
- FSM states S_LEN, S_DATA, S_WRITE, S_DONE, S_ERR:
  - S_LEN: collect 4 bytes into N.
    - N==0 → S_DONE.
    - N>MAX_WORDS → S_ERR.
    - Otherwise → S_DATA.
  - S_DATA: shift bytes into the word register. On the 4th valid byte → S_WRITE.
  - S_WRITE: exactly one cycle with ext_mem_write=1. ext_write_data holds the word and ext_data_adr = BASE_ADDR + 4*word_idx (32-bit wrap). Data and address are stable in that cycle. Next cycle: word_idx+1, then → S_DONE if word_idx+1==N, else → S_DATA.
  - S_DONE: cpu_reset_out=0 and load_done=1, starting the cycle after the last write strobe. All further UART bytes are ignored.
  - S_ERR: cpu_reset_out stays 1 and load_err=1 until reset. No writes occur.
- ext_mem_write is 0 in every state except S_WRITE. ext_data_adr holds its last value outside writes.
- A framing error never advances the byte counter.

Decomposition:
- Package uart_loader_pkg: FSM state enum, default CLKS_PER_BIT computation, word-size constant (4 bytes), address step constant (4).
- One sub-module, uart_rx: synchronizer, bit timer, 8N1 deserializer. Outputs rx_byte[7:0], rx_valid and frame_bad; ports clk and reset.

Test Plan:
All scenarios use CLK_FREQ=1000000, BAUD=100000 (CLKS_PER_BIT=10) and BASE_ADDR=0.
1. Send N=2, then words 0x00500113 and 0x00C00193 → two single-cycle writes at addresses 0x0 and 0x4 with the exact data; load_done=1 and cpu_reset_out=0 one cycle after the second strobe.
2. Send N=0 → no write strobes, load_done=1, cpu_reset_out=0.
3. Send N=MAX_WORDS+1 (0x401) → load_err=1, cpu_reset_out stays 1, no strobes even after further bytes.
4. Send N=1, then byte 0x13 with stop bit forced to 0, then 0x13, 0x01, 0x50, 0x00 → frame_err=1, one write of 0x00500113 at 0x0.
5. Send a 3-cycle low glitch on uart_rx while idle → no rx_valid, no state change.
6. Send N=2 and one word, assert reset for 1 cycle, then send N=1 and 0xDEADBEEF → exactly one write, at 0x0 with data 0xDEADBEEF; load_done=1.
